// File: rtl/game_status_ctrl_pkg.sv
// Shared game types and constants; the in-game and end-screen mappers import the same state enum.
package game_pkg;

   typedef enum logic [1:0] {IDLE, PLAY, WON, LOST} game_state_t;

   localparam int SCORE_MAX = 99;
   localparam int SCORE_W   = 7;
   localparam int PVAL_W    = 4;
   localparam int LIVES_W   = 3;
   localparam int TIME_W    = 12;
   localparam int CNT_W     = 12;

   // Add at 8 bits so 99+15 cannot wrap before the clamp
   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                  input logic [PVAL_W-1:0]  v);
      logic [7:0] sum;
      sum = {1'b0, s} + {4'b0000, v};
      return (sum > 8'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum[SCORE_W-1:0];
   endfunction

endpackage

// File: rtl/game_status_ctrl_if.sv
// Player-event inputs and game status outputs of the game-state controller.
interface game_status_ctrl_if;
   import game_pkg::*;

   logic               frame_clk;
   logic               start_key;
   logic               point_valid;
   logic [PVAL_W-1:0]  point_val;
   logic               hit_valid;
   logic               game_active;
   logic               is_won;
   logic               is_lost;
   logic [31:0]        score;
   logic [LIVES_W-1:0] lives;
   logic [TIME_W-1:0]  time_left;
   logic               invuln;

   modport master (
      output frame_clk, start_key, point_valid, point_val, hit_valid,
      input  game_active, is_won, is_lost, score, lives, time_left, invuln
   );

   modport slave (
      input  frame_clk, start_key, point_valid, point_val, hit_valid,
      output game_active, is_won, is_lost, score, lives, time_left, invuln
   );

endinterface

// File: rtl/game_status_ctrl_edge_detect.sv
// Two-flop rising-edge detector; pulse is one Clk wide, one cycle after the input rises.
module edge_detect #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic sig,
   output logic rise
);

   logic cur;
   logic prev;

   // RESET_VAL=1 makes a level already high at reset release look old, not new
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cur  <= RESET_VAL;
         prev <= RESET_VAL;
      end else begin
         cur  <= sig;
         prev <= cur;
      end
   end

   assign rise = cur & ~prev;

endmodule

// File: rtl/game_status_ctrl.sv
// Game-state controller: score, lives, round timer and title/play/won/lost sequencing.
// All outputs registered, one Clk after the input event; frame-based timing from VGA VS.
module game_status_ctrl
   import game_pkg::*;
#(
   parameter int WIN_SCORE     = 20,
   parameter int MAX_LIVES     = 3,
   parameter int ROUND_FRAMES  = 3600,
   parameter int INVULN_FRAMES = 60,
   parameter int HOLD_FRAMES   = 120
) (
   input logic                Clk,
   input logic                Reset_n,
   game_status_ctrl_if.slave  bus
);

   localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
   localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(MAX_LIVES);
   localparam logic [TIME_W-1:0]  TIME_INIT  = TIME_W'(ROUND_FRAMES);
   localparam logic [CNT_W-1:0]   INV_INIT   = CNT_W'(INVULN_FRAMES);
   localparam logic [CNT_W-1:0]   HOLD_INIT  = CNT_W'(HOLD_FRAMES);

   logic frame_tick;
   logic start_press;

   edge_detect #(.RESET_VAL(1'b0)) u_frame_edge (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .sig     (bus.frame_clk),
      .rise    (frame_tick)
   );

   edge_detect #(.RESET_VAL(1'b1)) u_start_edge (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .sig     (bus.start_key),
      .rise    (start_press)
   );

   game_state_t        state_q, state_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [LIVES_W-1:0] lives_q, lives_d;
   logic [TIME_W-1:0]  time_q,  time_d;
   logic [CNT_W-1:0]   inv_q,   inv_d;
   logic [CNT_W-1:0]   hold_q,  hold_d;
   logic               active_q, won_q, lost_q, invuln_q;
   logic               restart;

   // End screens only release once the hold has fully run out; early presses are dropped
   assign restart = start_press &&
                    ((state_q == IDLE) ||
                     (((state_q == WON) || (state_q == LOST)) && (hold_q == '0)));

   always_comb begin
      state_d = state_q;
      score_d = score_q;
      lives_d = lives_q;
      time_d  = time_q;
      inv_d   = inv_q;
      hold_d  = hold_q;

      unique case (state_q)
         IDLE: ;

         PLAY: begin
            if (bus.point_valid)
               score_d = sat_add(score_q, bus.point_val);

            // A fresh hit reloads the window; that reload wins over a same-cycle tick
            if (bus.hit_valid && (inv_q == '0)) begin
               lives_d = lives_q - 1'b1;
               inv_d   = INV_INIT;
            end else if (frame_tick && (inv_q != '0)) begin
               inv_d = inv_q - 1'b1;
            end

            if (frame_tick && (time_q != '0))
               time_d = time_q - 1'b1;

            if ((lives_d == '0) || (time_d == '0)) begin
               state_d = LOST;
               hold_d  = HOLD_INIT;
            end else if (score_d >= WIN_S) begin
               state_d = WON;
               hold_d  = HOLD_INIT;
            end
         end

         WON, LOST: begin
            if (frame_tick && (hold_q != '0))
               hold_d = hold_q - 1'b1;
         end

         default: state_d = IDLE;
      endcase

      if (restart) begin
         state_d = PLAY;
         score_d = '0;
         lives_d = LIVES_INIT;
         time_d  = TIME_INIT;
         inv_d   = '0;
         hold_d  = '0;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= IDLE;
         score_q  <= '0;
         lives_q  <= LIVES_INIT;
         time_q   <= TIME_INIT;
         inv_q    <= '0;
         hold_q   <= '0;
         active_q <= 1'b0;
         won_q    <= 1'b0;
         lost_q   <= 1'b0;
         invuln_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         score_q  <= score_d;
         lives_q  <= lives_d;
         time_q   <= time_d;
         inv_q    <= inv_d;
         hold_q   <= hold_d;
         active_q <= (state_d == PLAY);
         won_q    <= (state_d == WON);
         lost_q   <= (state_d == LOST);
         invuln_q <= (inv_d != '0);
      end
   end

   assign bus.game_active = active_q;
   assign bus.is_won      = won_q;
   assign bus.is_lost     = lost_q;
   assign bus.score       = {{(32-SCORE_W){1'b0}}, score_q};
   assign bus.lives       = lives_q;
   assign bus.time_left   = time_q;
   assign bus.invuln      = invuln_q;

endmodule

// File: tb/tb_game_status_ctrl.sv
// Directed bench for game_status_ctrl: scoreboarded expectations, checked on the falling edge.
module tb_game_status_ctrl;
   import game_pkg::*;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   always #10 Clk = ~Clk;

   game_status_ctrl_if bus ();
   game_status_ctrl_if sbus ();

   game_status_ctrl dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus.slave)
   );

   game_status_ctrl #(.ROUND_FRAMES(5)) dut_short (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (sbus.slave)
   );

   typedef struct {
      logic        active;
      logic        won;
      logic        lost;
      logic        inv;
      logic [31:0] score;
      logic [2:0]  lives;
      logic [11:0] time_left;
   } obs_t;

   obs_t sb_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge Clk);
   endtask

   task automatic push_exp(input bit act, input bit won, input bit lost, input bit inv,
                           input int sc, input int lv, input int tl);
      obs_t e;
      e.active    = act;
      e.won       = won;
      e.lost      = lost;
      e.inv       = inv;
      e.score     = 32'(sc);
      e.lives     = 3'(lv);
      e.time_left = 12'(tl);
      sb_q.push_back(e);
   endtask

   task automatic cmp(input string tag, input string field,
                      input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s.%s: got %0d expected %0d", tag, field, got, exp);
      end
   endtask

   task automatic check(input string tag, input bit short_dut);
      obs_t e, o;
      if (sb_q.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s: scoreboard holds 0 entries, expected 1", tag);
         return;
      end
      e = sb_q.pop_front();
      if (short_dut) begin
         o.active = sbus.game_active; o.won = sbus.is_won; o.lost = sbus.is_lost;
         o.inv = sbus.invuln; o.score = sbus.score; o.lives = sbus.lives;
         o.time_left = sbus.time_left;
      end else begin
         o.active = bus.game_active; o.won = bus.is_won; o.lost = bus.is_lost;
         o.inv = bus.invuln; o.score = bus.score; o.lives = bus.lives;
         o.time_left = bus.time_left;
      end
      cmp(tag, "game_active", 32'(o.active), 32'(e.active));
      cmp(tag, "is_won",      32'(o.won),    32'(e.won));
      cmp(tag, "is_lost",     32'(o.lost),   32'(e.lost));
      cmp(tag, "invuln",      32'(o.inv),    32'(e.inv));
      cmp(tag, "score",       o.score,       e.score);
      cmp(tag, "lives",       32'(o.lives),  32'(e.lives));
      cmp(tag, "time_left",   32'(o.time_left), 32'(e.time_left));
   endtask

   task automatic press(input bit short_dut);
      if (short_dut) sbus.start_key = 1'b1; else bus.start_key = 1'b1;
      cyc(2);
      if (short_dut) sbus.start_key = 1'b0; else bus.start_key = 1'b0;
      cyc(2);
   endtask

   task automatic frames(input int n, input bit short_dut);
      for (int i = 0; i < n; i++) begin
         if (short_dut) sbus.frame_clk = 1'b1; else bus.frame_clk = 1'b1;
         cyc(2);
         if (short_dut) sbus.frame_clk = 1'b0; else bus.frame_clk = 1'b0;
         cyc(2);
      end
   endtask

   task automatic event_pulse(input bit pt, input int val, input bit hit);
      bus.point_valid = pt;
      bus.point_val   = 4'(val);
      bus.hit_valid   = hit;
      @(negedge Clk);
      bus.point_valid = 1'b0;
      bus.point_val   = 4'd0;
      bus.hit_valid   = 1'b0;
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.frame_clk = 1'b0;  bus.start_key = 1'b0;  bus.point_valid = 1'b0;
      bus.point_val = 4'd0;  bus.hit_valid = 1'b0;
      sbus.frame_clk = 1'b0; sbus.start_key = 1'b0; sbus.point_valid = 1'b0;
      sbus.point_val = 4'd0; sbus.hit_valid = 1'b0;

      cyc(3);
      push_exp(0, 0, 0, 0, 0, 3, 3600); check("reset", 0);
      Reset_n = 1'b1;
      cyc(2);

      press(0);
      push_exp(1, 0, 0, 0, 0, 3, 3600); check("start", 0);

      event_pulse(1, 5, 0); push_exp(1, 0, 0, 0, 5, 3, 3600);  check("pt1", 0);
      event_pulse(1, 5, 0); push_exp(1, 0, 0, 0, 10, 3, 3600); check("pt2", 0);
      event_pulse(1, 5, 0); push_exp(1, 0, 0, 0, 15, 3, 3600); check("pt3", 0);
      event_pulse(1, 5, 0); push_exp(0, 1, 0, 0, 20, 3, 3600); check("win", 0);
      event_pulse(1, 5, 0); push_exp(0, 1, 0, 0, 20, 3, 3600); check("won_frozen", 0);

      press(0);             push_exp(0, 1, 0, 0, 20, 3, 3600); check("press_hold0", 0);
      frames(60, 0);
      press(0);             push_exp(0, 1, 0, 0, 20, 3, 3600); check("press_hold60", 0);
      frames(60, 0);
      press(0);             push_exp(1, 0, 0, 0, 0, 3, 3600);  check("restart_won", 0);

      event_pulse(0, 0, 1); push_exp(1, 0, 0, 1, 0, 2, 3600);  check("hit1", 0);
      frames(10, 0);
      event_pulse(0, 0, 1); push_exp(1, 0, 0, 1, 0, 2, 3590);  check("hit_invuln", 0);
      frames(50, 0);        push_exp(1, 0, 0, 0, 0, 2, 3540);  check("invuln_expired", 0);
      event_pulse(0, 0, 1); push_exp(1, 0, 0, 1, 0, 1, 3540);  check("hit3", 0);

      frames(60, 0);
      event_pulse(1, 5, 0);  push_exp(1, 0, 0, 0, 5, 1, 3480); check("pt_pre", 0);
      event_pulse(1, 15, 1); push_exp(0, 0, 1, 1, 20, 0, 3480); check("loss_beats_win", 0);

      press(1);             push_exp(1, 0, 0, 0, 0, 3, 5);     check("short_start", 1);
      frames(4, 1);         push_exp(1, 0, 0, 0, 0, 3, 1);     check("short_t1", 1);
      frames(1, 1);         push_exp(0, 0, 1, 0, 0, 3, 0);     check("timeout", 1);
      press(1);             push_exp(0, 0, 1, 0, 0, 3, 0);     check("timeout_hold", 1);
      frames(120, 1);
      press(1);             push_exp(1, 0, 0, 0, 0, 3, 5);     check("short_restart", 1);

      frames(120, 0);
      press(0);             push_exp(1, 0, 0, 0, 0, 3, 3600);  check("restart_lost", 0);
      event_pulse(1, 5, 0);
      event_pulse(1, 8, 0); push_exp(1, 0, 0, 0, 13, 3, 3600); check("score13", 0);

      // Reset lands mid-cycle with the start key already held
      bus.start_key = 1'b1;
      #3 Reset_n = 1'b0;
      #1;
      push_exp(0, 0, 0, 0, 0, 3, 3600); check("async_reset", 0);
      push_exp(0, 0, 0, 0, 0, 3, 5);    check("async_reset_short", 1);
      cyc(3);
      Reset_n = 1'b1;
      cyc(4);
      push_exp(0, 0, 0, 0, 0, 3, 3600); check("held_key_no_press", 0);
      bus.start_key = 1'b0;
      cyc(2);
      press(0);             push_exp(1, 0, 0, 0, 0, 3, 3600);  check("start_after_reset", 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/game_status_ctrl.md
Name: game_status_ctrl

Overview:
- Game-state controller directly upstream of the end-screen colour mapper.
- Tracks score, lives and the round timer, runs the title/play/won/lost state machine, and drives is_won, is_lost and score to the end-screen mapper.
- game_active selects between the in-game mapper and the end-screen mapper at the top level.
- All game-time counting is per video frame, derived from the VGA vertical sync.

Parameters:
- WIN_SCORE, 20, score at which the round is won (1..99).
- MAX_LIVES, 3, lives loaded at round start (1..7).
- ROUND_FRAMES, 3600, round length in frames (60 s at 60 Hz).
- INVULN_FRAMES, 60, frames after a hit during which further hits are ignored.
- HOLD_FRAMES, 120, frames an end screen is held before restart is accepted.

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous active-low reset
- frame_clk  in  1  VGA VS, level; rising edge = one frame tick
- start_key  in  1  level, high while start/restart key held
- point_valid  in  1  single-cycle pulse: add point_val to score
- point_val  in  4  points to add (0..15)
- hit_valid  in  1  single-cycle pulse: player damaged
- game_active  out  1  high in PLAY
- is_won  out  1  high in WON
- is_lost  out  1  high in LOST
- score  out  32  current score, unsigned 0..99, upper bits zero
- lives  out  3  remaining lives
- time_left  out  12  frames remaining in round
- invuln  out  1  high while the invulnerability counter is non-zero

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled at the top level):
  - state=IDLE, score=0, lives=MAX_LIVES, time_left=ROUND_FRAMES.
  - invuln=0, all flags 0, internal counters 0.
- Edge detectors:
  - frame_clk is registered once; frame_tick = cur & ~prev, one Clk wide.
  - start_key likewise; start_press = rising edge only. A held key never re-triggers.
- All outputs are registered and reflect an event one Clk after the input cycle.
- States:
  - IDLE: start_press → PLAY. On entry to PLAY: score=0, lives=MAX_LIVES, time_left=ROUND_FRAMES, invuln counter=0.
  - PLAY:
    - point_valid: score = min(score+point_val, 99).
    - hit_valid while invuln counter==0: lives -= 1 and invuln counter=INVULN_FRAMES. While the counter is non-zero, the hit is ignored.
    - frame_tick: time_left -= 1 if non-zero; invuln counter -= 1 if non-zero.
  - PLAY exit conditions, evaluated on the post-update values of the same cycle:
    - loss: lives==0 or time_left==0 → LOST.
    - else score>=WIN_SCORE → WON.
    - Loss beats win when both occur in the same cycle.
  - WON / LOST:
    - score, lives and time_left are frozen.
    - hold counter loaded with HOLD_FRAMES on entry, decremented per frame_tick.
    - start_press with hold counter==0 → PLAY (full reinit as above).
    - start_press while hold counter is non-zero is discarded, not queued.
- Inputs are ignored in states where they do not apply: point_valid and hit_valid outside PLAY, and start_press in PLAY.
- Arithmetic:
  - score is held internally in 7 bits and zero-extended to 32 bits.
  - The addition is done at 8 bits, then saturates to 99.
  - lives never underflows; a hit at lives==0 cannot occur because the state has already left PLAY.
- Reset mid-round returns immediately to IDLE with reset values. No partial state survives.

Decomposition:
- Shared package game_pkg:
  - typedef enum logic [1:0] game_state_t {IDLE, PLAY, WON, LOST}.
  - constant SCORE_MAX=99.
  - The end-screen and in-game mappers import the same enum.
- Sub-module edge_detect (one instance each for frame_clk and start_key): 2-flop register, rising-edge pulse output.

Test Plan:
- Reset, then start_press → game_active=1 next cycle, score=0, lives=3, time_left=3600.
- 4× point_valid with point_val=5 → score=20 and is_won=1 one cycle after the 4th pulse. A further point_valid leaves score=20.
- hit_valid, then a second hit_valid 10 frames later → lives=2 (second hit ignored, invuln=1). A third hit after 60 frame_ticks → lives=1.
- Same cycle: point_val=15 reaching score≥20 and a hit taking lives 1→0 → is_lost=1, is_won=0.
- ROUND_FRAMES=5: 5 frame_ticks in PLAY → time_left=0 and is_lost=1. start_press at frame 60 of hold is ignored; start_press after 120 ticks → PLAY, score=0, lives=3.
- Assert Reset_n low mid-PLAY with score=13 → all outputs return to reset values asynchronously. Holding start_key high across reset release produces no start_press.
